wbuhexline: RTL



---
 rtl/wbuhexline_if.sv | 28 ++
 rtl/wbuhexline.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wbuhexline_if.sv
// Token-in / byte-out handshake bundle for wbuhexline.
// slave: the line formatter itself; master: the side that feeds tokens and sinks bytes.
interface wbuhexline_if;
  logic       i_stb;
  logic [6:0] i_nl_hexbits;
  logic       o_busy;
  logic       o_stb;
  logic [7:0] o_char;
  logic       i_tx_busy;

  modport slave (
    input  i_stb,
    input  i_nl_hexbits,
    input  i_tx_busy,
    output o_busy,
    output o_stb,
    output o_char
  );

  modport master (
    output i_stb,
    output i_nl_hexbits,
    output i_tx_busy,
    input  o_busy,
    input  o_stb,
    input  o_char
  );
endinterface

// File: rtl/wbuhexline.sv
// Converts 7-bit {newline, hex} tokens to printable ASCII with line-length wrapping.
// Define WBUHEXLINE_CRLF_EN to emit every line break as CR LF instead of LF.
//
// state   | meaning
// IDLE    | waiting for a token, o_stb=0, o_busy=0
// SEND    | presenting a single byte (printable or LF)
// WRAP    | presenting the LF inserted ahead of an overlong line's next char
// PEND    | presenting the char that forced the wrap
// SEND_CR | CR of an explicit line break (CRLF build only)
// WRAP_CR | CR of an inserted line break (CRLF build only)
module wbuhexline #(
  parameter int LINELEN = 80
) (
  input logic        i_clk,
  input logic        i_areset_n,
  wbuhexline_if.slave bus
);

  localparam logic [7:0] LINE_MAX = 8'(LINELEN);
  localparam logic [7:0] CH_LF    = 8'h0A;
`ifdef WBUHEXLINE_CRLF_EN
  localparam logic [7:0] CH_CR    = 8'h0D;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WRAP,
    PEND
`ifdef WBUHEXLINE_CRLF_EN
    ,
    SEND_CR,
    WRAP_CR
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] char_q, char_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] col_q, col_d;
  logic       stb_q, stb_d;
  logic       busy_q, busy_d;

  logic       xfer;
  logic [7:0] col_inc;
  logic [7:0] hex_ch;

  function automatic logic [7:0] hex_char(input logic [5:0] v);
    logic [7:0] v8;
    v8 = {2'b00, v};
    if (v < 6'd10)      return 8'h30 + v8;
    else if (v < 6'd36) return 8'h41 + v8 - 8'd10;
    else if (v < 6'd62) return 8'h61 + v8 - 8'd36;
    else if (v == 6'd62) return 8'h40;
    else                return 8'h25;
  endfunction

  assign xfer    = stb_q && !bus.i_tx_busy;
  assign col_inc = (col_q < LINE_MAX) ? col_q + 8'd1 : col_q;
  assign hex_ch  = hex_char(bus.i_nl_hexbits[5:0]);

  assign bus.o_stb  = stb_q;
  assign bus.o_busy = busy_q;
  assign bus.o_char = char_q;

  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    pend_d  = pend_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (bus.i_stb) begin
          if (bus.i_nl_hexbits[6]) begin
            // A newline at column 0 would only produce an empty line
            if (col_q != 8'd0) begin
`ifdef WBUHEXLINE_CRLF_EN
              state_d = SEND_CR;
              char_d  = CH_CR;
`else
              state_d = SEND;
              char_d  = CH_LF;
`endif
            end
          end else if (col_q < LINE_MAX) begin
            state_d = SEND;
            char_d  = hex_ch;
          end else begin
            pend_d  = hex_ch;
`ifdef WBUHEXLINE_CRLF_EN
            state_d = WRAP_CR;
            char_d  = CH_CR;
`else
            state_d = WRAP;
            char_d  = CH_LF;
`endif
          end
        end
      end
      SEND: begin
        if (xfer) begin
          state_d = IDLE;
          // The mapping never yields 0x0A, so LF identifies a line break
          col_d   = (char_q == CH_LF) ? 8'd0 : col_inc;
        end
      end
      WRAP: begin
        if (xfer) begin
          state_d = PEND;
          char_d  = pend_q;
          col_d   = 8'd0;
        end
      end
      PEND: begin
        if (xfer) begin
          state_d = IDLE;
          col_d   = 8'd1;
        end
      end
`ifdef WBUHEXLINE_CRLF_EN
      SEND_CR: begin
        if (xfer) begin
          state_d = SEND;
          char_d  = CH_LF;
        end
      end
      WRAP_CR: begin
        if (xfer) begin
          state_d = WRAP;
          char_d  = CH_LF;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    stb_d  = (state_d != IDLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q <= IDLE;
      char_q  <= 8'h00;
      pend_q  <= 8'h00;
      col_q   <= 8'd0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      pend_q  <= pend_d;
      col_q   <= col_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
    end
  end

endmodule
